// File: rtl/rf215_iq_deframer.sv
// rf215_iq_deframer: per-channel word aligner for the AT86RF215 LVDS I/Q stream.
// Each channel shifts in one DDR bit pair per clock. It hunts for the I/Q sync
// pattern, confirms alignment over several words and then tracks word boundaries
// with miss tolerance. Aligned words are emitted as sign-extended I/Q samples.
`timescale 1ns/1ps
module rf215_iq_deframer #(
   parameter int NUM_CH     = 2,
   parameter int OUT_W      = 16,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int SWAP_DDR   = 0
) (
   input  logic                    delayedCLK,
   input  logic                    rst_n,
   input  logic [2*NUM_CH-1:0]     bit_pair,
   input  logic                    err_clr,
   output logic [OUT_W*NUM_CH-1:0] i_data,
   output logic [OUT_W*NUM_CH-1:0] q_data,
   output logic [2*NUM_CH-1:0]     ctrl_bits,
   output logic [NUM_CH-1:0]       iq_valid,
   output logic [NUM_CH-1:0]       locked,
   output logic [16*NUM_CH-1:0]    err_cnt
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      SYNCED = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

   // Saturating error counter update; a clear beats a same-cycle increment.
   function automatic logic [15:0] err_update(input logic [15:0] cnt, input logic inc,
                                              input logic clr);
      logic [15:0] res;
      res = cnt;
      if (clr) begin
         res = '0;
      end else if (inc && (cnt != 16'hFFFF)) begin
         res = cnt + 16'd1;
      end
      return res;
   endfunction

   // Sign-extend a 13-bit two's complement sample to OUT_W bits.
   function automatic logic [OUT_W-1:0] sext13(input logic [12:0] v);
      logic signed [12:0]      s;
      logic signed [OUT_W-1:0] r;
      s = v;
      r = s;
      return r;
   endfunction

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [1:0]       pair;
      logic [29:0]      sr;
      logic [31:0]      next_word;
      logic             good;
      logic             zero;
      logic [3:0]       wcnt;
      logic [3:0]       wcnt_nxt;
      logic [3:0]       hit;
      logic [3:0]       hit_nxt;
      logic [3:0]       miss;
      logic [3:0]       miss_nxt;
      state_t           state;
      state_t           state_nxt;
      logic             emit;
      logic             err_inc;
      logic [OUT_W-1:0] i_p1;
      logic [OUT_W-1:0] q_p1;
      logic [1:0]       ctrl_p1;
      logic             vld_p1;
      logic             locked_p1;
      logic [15:0]      err_p1;

      if (SWAP_DDR != 0) begin : g_swap
         assign pair = {bit_pair[2*c], bit_pair[2*c+1]};
      end else begin : g_noswap
         assign pair = bit_pair[2*c +: 2];
      end

      // Only the 30 most recent bits are kept; the incoming pair completes the 32-bit window.
      assign next_word = {sr, pair};
      assign good      = (next_word[31:30] == 2'b10) && (next_word[15:14] == 2'b01);
      assign zero      = (next_word == 32'h0);

      // Next-state logic: hunt every cycle, judge whole words only at the word boundary.
      always_comb begin
         state_nxt = state;
         hit_nxt   = hit;
         miss_nxt  = miss;
         wcnt_nxt  = wcnt + 4'd1;
         emit      = 1'b0;
         err_inc   = 1'b0;
         case (state)
            HUNT: begin
               if (good) begin
                  wcnt_nxt = 4'd0;
                  hit_nxt  = 4'd1;
                  miss_nxt = 4'd0;
                  if (LOCK_N == 4'd1) begin
                     state_nxt = SYNCED;
                     emit      = 1'b1;
                  end else begin
                     state_nxt = VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (wcnt == 4'd15) begin
                  if (good) begin
                     hit_nxt = hit + 4'd1;
                     if ((hit + 4'd1) == LOCK_N) begin
                        state_nxt = SYNCED;
                        miss_nxt  = 4'd0;
                        emit      = 1'b1;
                     end
                  end else if (!zero) begin
                     state_nxt = HUNT;
                     hit_nxt   = 4'd0;
                     err_inc   = 1'b1;
                  end
               end
            end
            SYNCED: begin
               if (wcnt == 4'd15) begin
                  if (good) begin
                     miss_nxt = 4'd0;
                     emit     = 1'b1;
                  end else if (!zero) begin
                     err_inc = 1'b1;
                     if ((miss + 4'd1) == UNLOCK_N) begin
                        state_nxt = HUNT;
                        miss_nxt  = 4'd0;
                        hit_nxt   = 4'd0;
                     end else begin
                        miss_nxt = miss + 4'd1;
                     end
                  end
               end
            end
            default: begin
               state_nxt = HUNT;
            end
         endcase
      end

      // Alignment state: shift register, word counter and hysteresis counters.
      always_ff @(posedge delayedCLK or negedge rst_n) begin
         if (!rst_n) begin
            state <= HUNT;
            sr    <= '0;
            wcnt  <= '0;
            hit   <= '0;
            miss  <= '0;
         end else begin
            state <= state_nxt;
            sr    <= next_word[29:0];
            wcnt  <= wcnt_nxt;
            hit   <= hit_nxt;
            miss  <= miss_nxt;
         end
      end

      // Output stage: one cycle after the word's last pair; data holds between emits.
      always_ff @(posedge delayedCLK or negedge rst_n) begin
         if (!rst_n) begin
            vld_p1    <= 1'b0;
            locked_p1 <= 1'b0;
            err_p1    <= '0;
            i_p1      <= '0;
            q_p1      <= '0;
            ctrl_p1   <= '0;
         end else begin
            vld_p1    <= emit;
            locked_p1 <= (state_nxt == SYNCED);
            err_p1    <= err_update(err_p1, err_inc, err_clr);
            if (emit) begin
               i_p1    <= sext13(next_word[29:17]);
               q_p1    <= sext13(next_word[13:1]);
               ctrl_p1 <= {next_word[16], next_word[0]};
            end
         end
      end

      assign i_data[c*OUT_W +: OUT_W] = i_p1;
      assign q_data[c*OUT_W +: OUT_W] = q_p1;
      assign ctrl_bits[2*c +: 2]      = ctrl_p1;
      assign iq_valid[c]              = vld_p1;
      assign locked[c]                = locked_p1;
      assign err_cnt[16*c +: 16]      = err_p1;
   end

endmodule

// File: tb/tb_rf215_iq_deframer.sv
// tb_rf215_iq_deframer: word-level vector table, hand sequences and randomized
// traffic for rf215_iq_deframer, with a cycle-by-cycle reference model.
`timescale 1ns/1ps
module tb_rf215_iq_deframer;

   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 3;
   localparam int M_SEARCH   = 10;
   localparam int M_CONFIRM  = 20;
   localparam int M_TRACK    = 30;

   logic        delayedCLK = 1'b0;
   logic        rst_n;
   logic [3:0]  bit_pair;
   logic [1:0]  bit_pair_sw;
   logic        err_clr;
   logic [31:0] i_data, q_data;
   logic [3:0]  ctrl_bits;
   logic [1:0]  iq_valid, locked;
   logic [31:0] err_cnt;
   logic [15:0] sw_i, sw_q, sw_err;
   logic [1:0]  sw_ctrl;
   logic [0:0]  sw_vld, sw_locked;

   always #5 delayedCLK = ~delayedCLK;

   rf215_iq_deframer #(.NUM_CH(2), .OUT_W(16), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT),
                       .SWAP_DDR(0)) dut (
      .delayedCLK(delayedCLK), .rst_n(rst_n), .bit_pair(bit_pair), .err_clr(err_clr),
      .i_data(i_data), .q_data(q_data), .ctrl_bits(ctrl_bits), .iq_valid(iq_valid),
      .locked(locked), .err_cnt(err_cnt));

   rf215_iq_deframer #(.NUM_CH(1), .OUT_W(16), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT),
                       .SWAP_DDR(1)) dut_sw (
      .delayedCLK(delayedCLK), .rst_n(rst_n), .bit_pair(bit_pair_sw), .err_clr(err_clr),
      .i_data(sw_i), .q_data(sw_q), .ctrl_bits(sw_ctrl), .iq_valid(sw_vld),
      .locked(sw_locked), .err_cnt(sw_err));

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state, one entry per channel of the main DUT.
   longint      cyc;
   logic [31:0] m_win [2];
   int          m_mode [2];
   longint      m_bound [2];
   int          m_goods [2];
   int          m_bads [2];
   logic [15:0] m_err [2];
   logic [15:0] m_i [2];
   logic [15:0] m_q [2];
   logic [1:0]  m_ctrl [2];
   logic        m_vld [2];
   logic        vld_seen;

   typedef struct {
      logic [31:0] w;
      logic        vld;
      logic        lock;
      logic [15:0] err;
      logic [15:0] i;
      logic [15:0] q;
      logic [1:0]  ctrl;
   } row_t;

   row_t tbl [19];

   function automatic logic [31:0] mk_word(input logic [12:0] i, input logic ic,
                                           input logic [12:0] q, input logic qc);
      return {2'b10, i, ic, 2'b01, q, qc};
   endfunction

   function automatic logic [15:0] sx13(input logic [12:0] v);
      int x;
      x = int'(v);
      if (x >= 4096) x = x - 8192;
      return 16'(x);
   endfunction

   function automatic logic [63:0] pack(input logic v, input logic l, input logic [15:0] e,
                                        input logic [15:0] i, input logic [15:0] q,
                                        input logic [1:0] ct);
      return {12'h0, v, l, e, i, q, ct};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_win[c] = '0; m_mode[c] = M_SEARCH; m_bound[c] = 0; m_goods[c] = 0;
         m_bads[c] = 0; m_err[c] = '0; m_i[c] = '0; m_q[c] = '0; m_ctrl[c] = '0;
         m_vld[c] = 1'b0;
      end
      cyc = 0;
   endtask

   // Advance the model by one clock using the pairs presented at that edge.
   task automatic model_step(input logic [1:0] p0, input logic [1:0] p1, input logic clr);
      logic [1:0] pr [2];
      logic good, zero, emit, bad;
      pr[0] = p0;
      pr[1] = p1;
      cyc++;
      for (int c = 0; c < 2; c++) begin
         m_win[c] = {m_win[c][29:0], pr[c]};
         good = (m_win[c][31:30] == 2'b10) && (m_win[c][15:14] == 2'b01);
         zero = (m_win[c] == 32'h0);
         emit = 1'b0;
         bad  = 1'b0;
         if (m_mode[c] == M_SEARCH) begin
            if (good) begin
               m_bound[c] = cyc + 16;
               m_goods[c] = 1;
               m_bads[c]  = 0;
               if (m_goods[c] >= LOCK_CNT) begin
                  m_mode[c] = M_TRACK;
                  emit = 1'b1;
               end else begin
                  m_mode[c] = M_CONFIRM;
               end
            end
         end else if (cyc == m_bound[c]) begin
            m_bound[c] = cyc + 16;
            if (good) begin
               if (m_mode[c] == M_CONFIRM) begin
                  m_goods[c]++;
                  if (m_goods[c] == LOCK_CNT) begin
                     m_mode[c] = M_TRACK;
                     m_bads[c] = 0;
                     emit = 1'b1;
                  end
               end else begin
                  m_bads[c] = 0;
                  emit = 1'b1;
               end
            end else if (!zero) begin
               bad = 1'b1;
               if (m_mode[c] == M_CONFIRM) begin
                  m_mode[c]  = M_SEARCH;
                  m_goods[c] = 0;
               end else begin
                  m_bads[c]++;
                  if (m_bads[c] == UNLOCK_CNT) begin
                     m_mode[c] = M_SEARCH;
                     m_bads[c] = 0;
                     m_goods[c] = 0;
                  end
               end
            end
         end
         if (clr) m_err[c] = '0;
         else if (bad && (m_err[c] != 16'hFFFF)) m_err[c] = m_err[c] + 16'd1;
         m_vld[c] = emit;
         if (emit) begin
            m_i[c]    = sx13(m_win[c][29:17]);
            m_q[c]    = sx13(m_win[c][13:1]);
            m_ctrl[c] = {m_win[c][16], m_win[c][0]};
         end
      end
   endtask

   task automatic compare_cycle();
      for (int c = 0; c < 2; c++) begin
         check($sformatf("cycle %0d ch%0d", cyc, c),
               pack(iq_valid[c], locked[c], err_cnt[16*c +: 16], i_data[16*c +: 16],
                    q_data[16*c +: 16], ctrl_bits[2*c +: 2]),
               pack(m_vld[c], m_mode[c] == M_TRACK, m_err[c], m_i[c], m_q[c], m_ctrl[c]));
      end
      check($sformatf("cycle %0d swapped", cyc),
            pack(sw_vld[0], sw_locked[0], sw_err, sw_i, sw_q, sw_ctrl),
            pack(m_vld[0], m_mode[0] == M_TRACK, m_err[0], m_i[0], m_q[0], m_ctrl[0]));
   endtask

   // Present one pair per channel (called just after a falling edge).
   task automatic clk_cycle(input logic [1:0] p0, input logic [1:0] p1, input logic clr);
      bit_pair    = {p1, p0};
      bit_pair_sw = {p0[0], p0[1]};
      err_clr     = clr;
      @(posedge delayedCLK);
      model_step(p0, p1, clr);
      @(negedge delayedCLK);
      compare_cycle();
      if (iq_valid[0]) vld_seen = 1'b1;
      err_clr = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w0, input logic [31:0] w1, input logic clr_last);
      vld_seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
         clk_cycle(w0[31-2*k -: 2], w1[31-2*k -: 2], clr_last && (k == 15));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] g, g2, g3, bq, bf, w0, w1;
      logic        prev_good;
      int          r;

      g  = mk_word(13'h0ABC, 1'b0, 13'h1F00, 1'b0);
      g2 = mk_word(13'h1234, 1'b1, 13'h0567, 1'b0);
      g3 = mk_word(13'h0001, 1'b0, 13'h1FFF, 1'b1);
      bq = g | 32'h0000_8000;
      bf = 32'hFFFF_FFFF;

      // w, valid, locked, err, i, q, ctrl after each complete word on ch0
      tbl[0]  = '{g,     1'b0, 1'b0, 16'd0, 16'h0000, 16'h0000, 2'b00};
      tbl[1]  = '{g,     1'b0, 1'b0, 16'd0, 16'h0000, 16'h0000, 2'b00};
      tbl[2]  = '{g,     1'b0, 1'b0, 16'd0, 16'h0000, 16'h0000, 2'b00};
      tbl[3]  = '{g,     1'b1, 1'b1, 16'd0, 16'h0ABC, 16'hFF00, 2'b00};
      tbl[4]  = '{g,     1'b1, 1'b1, 16'd0, 16'h0ABC, 16'hFF00, 2'b00};
      tbl[5]  = '{bq,    1'b0, 1'b1, 16'd1, 16'h0ABC, 16'hFF00, 2'b00};
      tbl[6]  = '{g2,    1'b1, 1'b1, 16'd1, 16'hF234, 16'h0567, 2'b10};
      tbl[7]  = '{bf,    1'b0, 1'b1, 16'd2, 16'hF234, 16'h0567, 2'b10};
      tbl[8]  = '{bf,    1'b0, 1'b1, 16'd3, 16'hF234, 16'h0567, 2'b10};
      tbl[9]  = '{bf,    1'b0, 1'b0, 16'd4, 16'hF234, 16'h0567, 2'b10};
      tbl[10] = '{g,     1'b0, 1'b0, 16'd4, 16'hF234, 16'h0567, 2'b10};
      tbl[11] = '{g,     1'b0, 1'b0, 16'd4, 16'hF234, 16'h0567, 2'b10};
      tbl[12] = '{g,     1'b0, 1'b0, 16'd4, 16'hF234, 16'h0567, 2'b10};
      tbl[13] = '{g,     1'b1, 1'b1, 16'd4, 16'h0ABC, 16'hFF00, 2'b00};
      tbl[14] = '{32'h0, 1'b0, 1'b1, 16'd4, 16'h0ABC, 16'hFF00, 2'b00};
      tbl[15] = '{g3,    1'b1, 1'b1, 16'd4, 16'h0001, 16'hFFFF, 2'b01};
      tbl[16] = '{32'h0, 1'b0, 1'b1, 16'd4, 16'h0001, 16'hFFFF, 2'b01};
      tbl[17] = '{32'h0, 1'b0, 1'b1, 16'd4, 16'h0001, 16'hFFFF, 2'b01};
      tbl[18] = '{g,     1'b1, 1'b1, 16'd4, 16'h0ABC, 16'hFF00, 2'b00};

      rst_n = 1'b0; bit_pair = '0; bit_pair_sw = '0; err_clr = 1'b0; vld_seen = 1'b0;
      model_reset();
      repeat (3) @(posedge delayedCLK);
      #1;
      check("reset valid/locked", {60'h0, iq_valid, locked}, 64'h0);
      check("reset err_cnt", {32'h0, err_cnt}, 64'h0);
      check("reset i_data", {32'h0, i_data}, 64'h0);
      check("reset q_data/ctrl", {28'h0, q_data, ctrl_bits}, 64'h0);
      @(negedge delayedCLK);
      rst_n = 1'b1;

      // Word-level vector table on ch0, ch1 idle
      for (int n = 0; n < 19; n++) begin
         send_word(tbl[n].w, 32'h0, 1'b0);
         check($sformatf("row %0d iq_valid", n), {63'h0, vld_seen}, {63'h0, tbl[n].vld});
         check($sformatf("row %0d locked", n), {63'h0, locked[0]}, {63'h0, tbl[n].lock});
         check($sformatf("row %0d err_cnt", n), {48'h0, err_cnt[15:0]}, {48'h0, tbl[n].err});
         check($sformatf("row %0d i_data", n), {48'h0, i_data[15:0]}, {48'h0, tbl[n].i});
         check($sformatf("row %0d q_data", n), {48'h0, q_data[15:0]}, {48'h0, tbl[n].q});
         check($sformatf("row %0d ctrl", n), {62'h0, ctrl_bits[1:0]}, {62'h0, tbl[n].ctrl});
      end

      // Clear arriving on the same edge as a framing error leaves zero
      send_word(bf, 32'h0, 1'b1);
      check("clr beats increment", {48'h0, err_cnt[15:0]}, 64'h0);
      check("lock held after single miss", {63'h0, locked[0]}, 64'h1);
      send_word(g, 32'h0, 1'b0);
      check("emit after single miss", {63'h0, vld_seen}, 64'h1);

      // Randomized traffic: ch0 stays framed, ch1 is noise
      prev_good = 1'b1;
      for (int n = 0; n < 50; n++) begin
         r = int'($urandom_range(0, 9));
         w0 = mk_word(13'($urandom), 1'($urandom), 13'($urandom), 1'($urandom));
         if (r == 0) begin
            w0 = 32'h0;
         end else if ((r == 1) && prev_good) begin
            w0 = w0 ^ 32'h4000_0000;
         end
         prev_good = (w0 != 32'h0) && (w0[31:30] == 2'b10);
         w1 = $urandom;
         send_word(w0, w1, $urandom_range(0, 11) == 0);
      end
      check("ch0 locked under ch1 noise", {63'h0, locked[0]}, 64'h1);
      check("ch1 lock tracks model", {63'h0, locked[1]}, {63'h0, m_mode[1] == M_TRACK});

      // err_clr pulse clears every channel
      clk_cycle(2'b00, 2'b00, 1'b1);
      check("err_clr all channels", {32'h0, err_cnt}, 64'h0);

      // Asynchronous reset in the middle of a word
      for (int k = 0; k < 8; k++) clk_cycle(g[31-2*k -: 2], 2'b00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midword reset valid/locked", {60'h0, iq_valid, locked}, 64'h0);
      check("midword reset err_cnt", {32'h0, err_cnt}, 64'h0);
      check("midword reset data", {i_data, q_data}, 64'h0);
      check("midword reset swapped", {sw_vld, sw_locked, sw_i, sw_q}, 64'h0);
      model_reset();
      @(posedge delayedCLK);
      @(negedge delayedCLK);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) clk_cycle(2'b00, 2'b00, 1'b0);
      for (int n = 0; n < 3; n++) begin
         send_word(g, 32'h0, 1'b0);
         check($sformatf("relock word %0d no valid", n), {63'h0, vld_seen}, 64'h0);
      end
      send_word(g, 32'h0, 1'b0);
      check("relock word 3 valid", {63'h0, vld_seen}, 64'h1);
      check("relock locked", {62'h0, locked}, 64'h1);
      check("relock i_data", {48'h0, i_data[15:0]}, 64'h0ABC);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
